switch_port: RTL and testbench



---
 rtl/switch_port.sv | 162 ++++++++++++++++
 tb/tb_switch_port.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_port.sv
// Ingress port: parses framed packets into a store-and-forward payload FIFO plus
// a descriptor FIFO, then replays each complete packet with dest/length tags.
module switch_port #(
   parameter int DEPTH = 512,
   parameter int PKTS  = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_sop,
   input  logic        wr_eop,
   input  logic        wr_vld,
   input  logic [15:0] wr_data,
   input  logic        xfer_stop,
   output logic [3:0]  dest_port,
   output logic [15:0] data,
   output logic        data_vld,
   output logic [8:0]  length,
   output logic [1:0]  rx_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = $clog2(PKTS);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [PW:0] PKTS_W  = (PW+1)'(PKTS);
   localparam logic [AW:0] P_ONE   = (AW+1)'(1);
   localparam logic [PW:0] D_ONE   = (PW+1)'(1);

   typedef enum logic [1:0] {IDLE = 2'd0, CTRL = 2'd1, DATA = 2'd2} rx_state_t;

   typedef struct packed {
      logic [3:0]  dest;
      logic [8:0]  len;
      logic [AW:0] cnt;
   } desc_t;

   rx_state_t   state_q, state_d;
   logic [15:0] pay_mem [DEPTH];
   desc_t       desc_mem [PKTS];

   logic [AW:0] wr_ptr, pkt_start, rd_ptr, pay_used, rx_cnt, cnt_now, cur_rem;
   logic [PW:0] dwr_ptr, drd_ptr, desc_used;
   logic [3:0]  rx_dest, cur_dest;
   logic [8:0]  rx_len, cur_len;
   logic        rx_drop, cur_first;
   logic        tx_emit, tx_pop, desc_empty, pay_full, desc_full;
   logic        in_data, wr_en, overflow, commit, abort_pkt;
   logic        prio_unused;

   // Priority bits are parsed from the control word but not forwarded.
   assign prio_unused = ^wr_data[6:4];

   // Transmit pops the next descriptor while emitting the last word of the
   // current packet, so consecutive packets stream without a gap.
   assign tx_emit    = !xfer_stop && (cur_rem != '0);
   assign desc_empty = (dwr_ptr == drd_ptr);
   assign tx_pop     = !xfer_stop && !desc_empty && (cur_rem <= P_ONE);

   // Occupancy includes the uncommitted words of the packet being received.
   assign pay_used  = wr_ptr - rd_ptr;
   assign pay_full  = (pay_used == DEPTH_W) && !tx_emit;
   assign desc_used = dwr_ptr - drd_ptr;
   assign desc_full = (desc_used == PKTS_W) && !tx_pop;

   assign in_data   = (state_q == DATA);
   assign wr_en     = in_data && wr_vld && !rx_drop && !pay_full;
   assign overflow  = in_data && wr_vld && !rx_drop && pay_full;
   assign cnt_now   = rx_cnt + {{AW{1'b0}}, wr_en};
   assign commit    = in_data && wr_eop && !rx_drop && !overflow &&
                      (cnt_now != '0) && !desc_full;
   assign abort_pkt = in_data && wr_eop && !commit;

   assign rx_state = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (wr_sop) state_d = CTRL;
         CTRL: begin
            if (wr_eop)      state_d = IDLE;
            else if (wr_vld) state_d = DATA;
         end
         DATA: if (wr_eop) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         pkt_start <= '0;
         rx_cnt    <= '0;
         rx_drop   <= 1'b0;
         rx_dest   <= '0;
         rx_len    <= '0;
         dwr_ptr   <= '0;
      end else begin
         if (state_q == CTRL && wr_vld && !wr_eop) begin
            rx_dest <= wr_data[3:0];
            rx_len  <= wr_data[15:7];
            rx_cnt  <= '0;
            rx_drop <= 1'b0;
         end
         if (wr_en) begin
            wr_ptr <= wr_ptr + P_ONE;
            rx_cnt <= cnt_now;
         end
         if (overflow) rx_drop <= 1'b1;
         if (commit) begin
            pkt_start <= wr_ptr + {{AW{1'b0}}, wr_en};
            dwr_ptr   <= dwr_ptr + D_ONE;
         end
         // Dropped or empty packet: discard everything written since its start.
         if (abort_pkt) wr_ptr <= pkt_start;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)  pay_mem[wr_ptr[AW-1:0]] <= wr_data;
      if (commit) desc_mem[dwr_ptr[PW-1:0]] <= desc_t'{dest: rx_dest, len: rx_len, cnt: cnt_now};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr    <= '0;
         drd_ptr   <= '0;
         cur_rem   <= '0;
         cur_first <= 1'b0;
         cur_dest  <= '0;
         cur_len   <= '0;
         dest_port <= '0;
         length    <= '0;
         data      <= '0;
         data_vld  <= 1'b0;
      end else begin
         data_vld <= tx_emit;
         if (tx_emit) begin
            data   <= pay_mem[rd_ptr[AW-1:0]];
            rd_ptr <= rd_ptr + P_ONE;
            if (cur_first) begin
               dest_port <= cur_dest;
               length    <= cur_len;
            end
         end
         if (tx_pop) begin
            cur_rem   <= desc_mem[drd_ptr[PW-1:0]].cnt;
            cur_dest  <= desc_mem[drd_ptr[PW-1:0]].dest;
            cur_len   <= desc_mem[drd_ptr[PW-1:0]].len;
            cur_first <= 1'b1;
            drd_ptr   <= drd_ptr + D_ONE;
         end else if (tx_emit) begin
            cur_rem   <= cur_rem - P_ONE;
            cur_first <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_switch_port.sv
// Directed plus randomized bench for switch_port with a packet-level reference
// model (expected word queue and occupancy counters).
module tb_switch_port;
   localparam int DEPTH = 512;
   localparam int PKTS  = 8;
   localparam int W     = 30;  // {first, dest[3:0], len[8:0], data[15:0]}

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_sop = 1'b0;
   logic        wr_eop = 1'b0;
   logic        wr_vld = 1'b0;
   logic [15:0] wr_data = '0;
   logic        xfer_stop = 1'b0;
   logic [3:0]  dest_port;
   logic [15:0] data;
   logic        data_vld;
   logic [8:0]  length;
   logic [1:0]  rx_state;

   int total = 0;
   int bad = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] e;
   int model_words = 0;
   int model_pkts = 0;
   int run_len = 0;
   int max_run = 0;
   logic stop_prev;
   bit rand_stop_en = 1'b0;

   switch_port #(.DEPTH(DEPTH), .PKTS(PKTS)) dut (
      .clk(clk), .rst_n(rst_n), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld),
      .wr_data(wr_data), .xfer_stop(xfer_stop), .dest_port(dest_port), .data(data),
      .data_vld(data_vld), .length(length), .rx_state(rx_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) stop_prev <= 1'b0;
      else        stop_prev <= xfer_stop;
   end

   // Scoreboard: every output word must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (stop_prev) chk("stop_gap", data_vld, 0);
         if (data_vld) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) chk("unexpected_word", exp_q.size(), 1);
            else begin
               e = exp_q.pop_front();
               chk("data", data, e[15:0]);
               chk("length", length, e[24:16]);
               chk("dest", dest_port, e[28:25]);
               model_words--;
               if (e[29]) model_pkts--;
            end
         end else run_len = 0;
      end
   end

   always @(negedge clk) begin
      if (rand_stop_en) xfer_stop = ($urandom_range(0, 3) == 0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input logic [3:0] dest, input logic [8:0] lenf, input int n,
                           input bit seq, input bit gaps);
      logic [15:0] w[$];
      bit ok;
      step(); wr_sop = 1'b1;
      step(); wr_sop = 1'b0; wr_vld = 1'b1;
      wr_data = {lenf, 3'($urandom_range(0, 7)), dest};
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            step(); wr_vld = 1'b0;
         end
         step();
         w.push_back(seq ? 16'(i) : 16'($urandom));
         wr_vld = 1'b1;
         wr_data = w[i];
      end
      step(); wr_vld = 1'b0; wr_eop = 1'b1;
      step(); wr_eop = 1'b0;
      ok = (n > 0) && (model_words + n <= DEPTH) && (model_pkts < PKTS);
      if (ok) begin
         model_words += n;
         model_pkts++;
         for (int i = 0; i < n; i++)
            exp_q.push_back({((i == 0) ? 1'b1 : 1'b0), dest, lenf, w[i]});
      end
   endtask

   task automatic drain(input string tag, input int budget);
      int c = 0;
      while (exp_q.size() != 0 && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk(tag, exp_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_vld(input string tag, input int budget);
      int c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!data_vld && c < budget);
      chk(tag, data_vld, 1);
   endtask

   initial begin
      #12;
      chk("rst_vld", data_vld, 0);
      chk("rst_data", data, 0);
      chk("rst_dest", dest_port, 0);
      chk("rst_len", length, 0);
      chk("rst_state", rx_state, 0);
      step(); rst_n = 1'b1;

      // Basic packet and first-word latency after eop.
      send_pkt(4'd5, 9'd32, 32, 1'b1, 1'b0);
      @(negedge clk); chk("lat_c0", data_vld, 0);
      @(negedge clk); chk("lat_c1", data_vld, 0);
      @(negedge clk); chk("lat_c2", data_vld, 1);
      chk("basic_dest", dest_port, 5);
      chk("basic_len", length, 32);
      chk("basic_w0", data, 0);
      drain("basic_drain", 200);

      // Back-pressure for 10 cycles starting at word 8.
      send_pkt(4'd5, 9'd32, 32, 1'b1, 1'b0);
      wait_vld("bp_start", 20);
      repeat (7) @(negedge clk);
      chk("bp_w7", data, 7);
      xfer_stop = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_hold", data_vld, 0);
      end
      chk("bp_hold_data", data, 7);
      xfer_stop = 1'b0;
      @(negedge clk);
      chk("bp_resume", data_vld, 1);
      chk("bp_w8", data, 8);
      drain("bp_drain", 200);

      // Back-to-back packets stream contiguously.
      max_run = 0;
      send_pkt(4'd3, 9'd40, 40, 1'b0, 1'b0);
      send_pkt(4'd12, 9'd33, 33, 1'b0, 1'b0);
      drain("b2b_drain", 300);
      chk("b2b_run", max_run, 73);

      // Payload overflow while stopped: third packet dropped, fourth fills exactly.
      step(); xfer_stop = 1'b1;
      send_pkt(4'd1, 9'd200, 200, 1'b0, 1'b0);
      send_pkt(4'd2, 9'd200, 200, 1'b0, 1'b0);
      send_pkt(4'd3, 9'd200, 200, 1'b0, 1'b0);
      send_pkt(4'd4, 9'd112, 112, 1'b0, 1'b0);
      repeat (5) step();
      chk("ovf_quiet", data_vld, 0);
      max_run = 0;
      xfer_stop = 1'b0;
      drain("ovf_drain", 1500);
      chk("ovf_run", max_run, 512);

      // Descriptor FIFO full: ninth packet dropped.
      step(); xfer_stop = 1'b1;
      for (int i = 0; i < PKTS + 1; i++) send_pkt(4'(i), 9'd3, 3, 1'b0, 1'b0);
      step(); xfer_stop = 1'b0;
      drain("dfull_drain", 200);

      // Length mismatch: length field 50, 48 words.
      send_pkt(4'd6, 9'd50, 48, 1'b0, 1'b0);
      drain("mism_drain", 200);

      // Zero-payload packet and eop during CTRL produce nothing.
      send_pkt(4'd7, 9'd4, 0, 1'b0, 1'b0);
      step(); wr_sop = 1'b1;
      step(); wr_sop = 1'b0; wr_eop = 1'b1;
      step(); wr_eop = 1'b0;
      repeat (6) @(negedge clk);
      chk("empty_none", data_vld, 0);
      send_pkt(4'd8, 9'd4, 4, 1'b0, 1'b0);
      drain("after_abort_drain", 100);

      // Randomized traffic with random back-pressure and input gaps.
      rand_stop_en = 1'b1;
      for (int p = 0; p < 6; p++)
         send_pkt(4'($urandom), 9'($urandom), int'($urandom_range(1, 60)), 1'b0, 1'b1);
      step(); rand_stop_en = 1'b0; xfer_stop = 1'b0;
      drain("rand_drain", 1000);

      // Reset in the middle of DATA.
      step(); wr_sop = 1'b1;
      step(); wr_sop = 1'b0; wr_vld = 1'b1; wr_data = 16'h1007;
      for (int i = 0; i < 5; i++) begin
         step(); wr_data = 16'(i + 100);
      end
      step(); wr_vld = 1'b0; rst_n = 1'b0;
      #1;
      chk("mrst_vld", data_vld, 0);
      chk("mrst_data", data, 0);
      chk("mrst_dest", dest_port, 0);
      chk("mrst_len", length, 0);
      chk("mrst_state", rx_state, 0);
      exp_q.delete();
      model_words = 0;
      model_pkts = 0;
      repeat (2) step();
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("mrst_quiet", data_vld, 0);
      send_pkt(4'd9, 9'd20, 20, 1'b1, 1'b0);
      drain("mrst_drain", 200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
